// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared types and constants for the USB receive control unit
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE, SYNC, PID, DATA, STORE, EOP_WAIT, ERR_WAIT, DONE
  } state_t;

  typedef enum logic [2:0] {
    PID_NONE  = 3'd0,
    PID_OUT   = 3'd1,
    PID_IN    = 3'd2,
    PID_DATA0 = 3'd3,
    PID_DATA1 = 3'd4,
    PID_ACK   = 3'd5,
    PID_NAK   = 3'd6,
    PID_BAD   = 3'd7
  } pid_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [6:0] MAX_BYTES = 7'd64;

  function automatic logic is_data_pid(input pid_t p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_pid_decode.sv
// rtl/usb_pid_decode.sv - combinational PID byte to packet-type decoder
module usb_pid_decode
  import usb_pkg::*;
(
  input  logic [7:0] pid_byte_i,
  output pid_t       pid_o
);

  always_comb begin
    pid_o = PID_BAD;
    case (pid_byte_i)
      8'hE1:   pid_o = PID_OUT;
      8'h69:   pid_o = PID_IN;
      8'hC3:   pid_o = PID_DATA0;
      8'h4B:   pid_o = PID_DATA1;
      8'hD2:   pid_o = PID_ACK;
      8'h5A:   pid_o = PID_NAK;
      default: pid_o = PID_BAD;
    endcase
  end

endmodule

// File: rtl/usb_rx_rcu.sv
// rtl/usb_rx_rcu.sv - USB receive control unit: sync/PID/data sequencing and FIFO strobes
module usb_rx_rcu
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       enable_timer,
  output logic       w_enable,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       r_error
);

  state_t     state_q, state_d;
  pid_t       pid_dec;
  pid_t       rx_packet_q;
  logic       r_error_q;
  logic       active_q;
  logic [6:0] byte_cnt_q;
  logic       mid_byte_q;
  logic       eop_seen_q;
  logic       sync_hit;

  usb_pid_decode u_pid_decode (
    .pid_byte_i (rcv_data),
    .pid_o      (pid_dec)
  );

  assign sync_hit = (state_q == SYNC) && byte_received && (rcv_data == SYNC_BYTE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (d_edge) state_d = SYNC;
      SYNC:     if (byte_received) state_d = (rcv_data == SYNC_BYTE) ? PID : ERR_WAIT;
      PID: begin
        if (byte_received) begin
          if (is_data_pid(pid_dec))   state_d = DATA;
          else if (pid_dec == PID_BAD) state_d = ERR_WAIT;
          else                         state_d = EOP_WAIT;
        end
      end
      // a byte beats a coincident EOP; the 65th byte overflows the packet
      DATA: begin
        if (byte_received)             state_d = (byte_cnt_q >= MAX_BYTES) ? ERR_WAIT : STORE;
        else if (eop && shift_enable)  state_d = mid_byte_q ? ERR_WAIT : DONE;
      end
      STORE:    state_d = DATA;
      EOP_WAIT: begin
        if (byte_received)             state_d = ERR_WAIT;
        else if (eop && shift_enable)  state_d = DONE;
      end
      ERR_WAIT: if (eop_seen_q && !eop) state_d = IDLE;
      DONE:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_packet_q <= PID_NONE;
      r_error_q   <= 1'b0;
      active_q    <= 1'b0;
      byte_cnt_q  <= 7'd0;
      mid_byte_q  <= 1'b0;
      eop_seen_q  <= 1'b0;
    end else begin
      if (sync_hit)                               rx_packet_q <= PID_NONE;
      else if (state_q == PID && byte_received)   rx_packet_q <= pid_dec;

      if (state_q == IDLE && d_edge)              r_error_q <= 1'b0;
      else if (state_d == ERR_WAIT)               r_error_q <= 1'b1;

      if (state_d == IDLE)                        active_q <= 1'b0;
      else if (sync_hit)                          active_q <= 1'b1;

      if (state_q == IDLE)                        byte_cnt_q <= 7'd0;
      else if (state_q == STORE && byte_cnt_q != 7'h7F) byte_cnt_q <= byte_cnt_q + 7'd1;

      // tracks bits sampled since the last byte boundary; an EOP overlapping a byte counts as early
      if (state_q == IDLE)                        mid_byte_q <= 1'b0;
      else if (byte_received)                     mid_byte_q <= eop;
      else if (shift_enable && !eop)              mid_byte_q <= 1'b1;

      eop_seen_q <= (state_q == ERR_WAIT) ? (eop_seen_q | eop) : eop;
    end
  end

  always_comb begin
    enable_timer       = !(state_q inside {IDLE, DONE});
    w_enable           = (state_q == STORE);
    rx_data_ready      = (state_q == DONE) && is_data_pid(rx_packet_q);
    rx_packet          = rx_packet_q;
    rx_transfer_active = active_q;
    r_error            = r_error_q;
  end

endmodule

// File: tb/tb_usb_rx_rcu.sv
// tb/tb_usb_rx_rcu.sv - scoreboard bench for usb_rx_rcu with a packet-level reference model
module tb_usb_rx_rcu;

  logic       clk = 1'b0;
  logic       rst, d_edge, eop, shift_enable, byte_received;
  logic [7:0] rcv_data;
  logic       enable_timer, w_enable, rx_data_ready, rx_transfer_active, r_error;
  logic [2:0] rx_packet;

  usb_rx_rcu dut (
    .clk                (clk),
    .rst                (rst),
    .d_edge             (d_edge),
    .eop                (eop),
    .shift_enable       (shift_enable),
    .byte_received      (byte_received),
    .rcv_data           (rcv_data),
    .enable_timer       (enable_timer),
    .w_enable           (w_enable),
    .rx_packet          (rx_packet),
    .rx_data_ready      (rx_data_ready),
    .rx_transfer_active (rx_transfer_active),
    .r_error            (r_error)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_WEN, EV_RDY, EV_END} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       pkt;
    int       err;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   eop_cyc = -100;
  int   model_pkt = 0;
  bit   mon_en = 0;
  logic prev_et = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic take(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", int'(k), -1);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", int'(k), int'(e.kind));
    if (k == EV_END && e.kind == EV_END) begin
      chk("rx_packet_at_end", int'(rx_packet), e.pkt);
      chk("r_error_at_end", int'(r_error), e.err);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (w_enable) take(EV_WEN);
      if (rx_data_ready) begin
        take(EV_RDY);
        chk("rdy_latency", cyc - eop_cyc, 1);
      end
      if (prev_et && !enable_timer) take(EV_END);
    end
    prev_et = enable_timer;
  end

  function automatic int pid_of(input logic [7:0] b);
    case (b)
      8'hE1: return 1;
      8'h69: return 2;
      8'hC3: return 3;
      8'h4B: return 4;
      8'hD2: return 5;
      8'h5A: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic ev_t mk(input ev_kind_t k, input int p, input int e);
    ev_t r;
    r.kind = k;
    r.pkt  = p;
    r.err  = e;
    return r;
  endfunction

  // Packet-level expectation: what the FIFO, ready flag and status should show for a whole packet.
  task automatic model_packet(input logic [7:0] bytes[$], input int partial);
    int wen = 0;
    int rdy = 0;
    int err = 0;
    int n;
    if (bytes[0] != 8'h80) err = 1;
    else begin
      model_pkt = pid_of(bytes[1]);
      n = bytes.size() - 2;
      if (model_pkt == 7) err = 1;
      else if (model_pkt == 3 || model_pkt == 4) begin
        if (n > 64) begin wen = 64; err = 1; end
        else begin
          wen = n;
          if (partial > 0) err = 1; else rdy = 1;
        end
      end else if (n > 0) err = 1;
    end
    for (int i = 0; i < wen; i++) exp_q.push_back(mk(EV_WEN, 0, 0));
    if (rdy != 0) exp_q.push_back(mk(EV_RDY, 0, 0));
    exp_q.push_back(mk(EV_END, model_pkt, err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      shift_enable  = 1'b0;
      byte_received = 1'b0;
      d_edge        = stray && ($urandom_range(0, 7) == 0);
      tick();
    end
    d_edge = 1'b0;
  endtask

  task automatic strobe(input bit byte_end, input logic [7:0] b);
    idle($urandom_range(1, 3), 1'b1);
    shift_enable  = 1'b1;
    byte_received = byte_end;
    rcv_data      = byte_end ? b : 8'($urandom);
    tick();
    shift_enable  = 1'b0;
    byte_received = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 7; i++) strobe(1'b0, 8'h00);
    strobe(1'b1, b);
  endtask

  task automatic end_packet();
    idle(2, 1'b1);
    eop = 1'b1;
    tick();
    shift_enable = 1'b1;
    eop_cyc = cyc;
    tick();
    shift_enable = 1'b0;
    tick();
    tick();
    eop = 1'b0;
    idle(3, 1'b0);
    chk("idle_transfer_active", int'(rx_transfer_active), 0);
    chk("idle_enable_timer", int'(enable_timer), 0);
  endtask

  task automatic send_packet(input logic [7:0] bytes[$], input int partial);
    model_packet(bytes, partial);
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    chk("r_error_cleared_by_d_edge", int'(r_error), 0);
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i]);
      if (i == 0) chk("transfer_active_after_sync", int'(rx_transfer_active), (bytes[0] == 8'h80) ? 1 : 0);
    end
    for (int i = 0; i < partial; i++) strobe(1'b0, 8'h00);
    end_packet();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_enable_timer"}, int'(enable_timer), 0);
    chk({tag, "_w_enable"}, int'(w_enable), 0);
    chk({tag, "_rx_packet"}, int'(rx_packet), 0);
    chk({tag, "_rx_data_ready"}, int'(rx_data_ready), 0);
    chk({tag, "_rx_transfer_active"}, int'(rx_transfer_active), 0);
    chk({tag, "_r_error"}, int'(r_error), 0);
  endtask

  logic [7:0] q[$];
  logic [7:0] toks[4];

  initial begin
    toks = '{8'hE1, 8'h69, 8'hD2, 8'h5A};
    rst = 1'b1; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0;
    byte_received = 1'b0; rcv_data = 8'h00;
    idle(3, 1'b0);
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    mon_en = 1;

    q = '{8'h80, 8'hC3, 8'h11, 8'h22};
    send_packet(q, 0);
    q = '{8'h80, 8'hD2};
    send_packet(q, 0);
    q = '{8'h81};
    send_packet(q, 0);
    q = '{8'h80, 8'h77};
    send_packet(q, 0);
    q = '{8'h80, 8'h4B};
    for (int i = 0; i < 65; i++) q.push_back(8'($urandom));
    send_packet(q, 0);
    q = '{8'h80, 8'hC3, 8'h5C};
    send_packet(q, 3);
    q = '{8'h80, 8'h69, 8'h01};
    send_packet(q, 0);

    // reset while two data bytes are already stored
    exp_q.push_back(mk(EV_WEN, 0, 0));
    exp_q.push_back(mk(EV_WEN, 0, 0));
    exp_q.push_back(mk(EV_END, 0, 0));
    model_pkt = 0;
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    send_byte(8'h80);
    send_byte(8'h4B);
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_packet_reset");
    idle(3, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int kind = $urandom_range(0, 4);
      int partial = 0;
      logic [7:0] b;
      q = {};
      case (kind)
        0, 1: begin
          q.push_back(8'h80);
          q.push_back($urandom_range(0, 1) ? 8'hC3 : 8'h4B);
          for (int i = 0; i < $urandom_range(0, 6); i++) q.push_back(8'($urandom));
          if ($urandom_range(0, 3) == 0) partial = $urandom_range(1, 7);
        end
        2: begin
          q.push_back(8'h80);
          q.push_back(toks[$urandom_range(0, 3)]);
          if ($urandom_range(0, 3) == 0) q.push_back(8'($urandom));
        end
        3: begin
          do b = 8'($urandom); while (b == 8'h80);
          q.push_back(b);
        end
        default: begin
          do b = 8'($urandom); while (pid_of(b) != 7);
          q.push_back(8'h80);
          q.push_back(b);
        end
      endcase
      send_packet(q, partial);
    end

    idle(20, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_rcu.md
USB_RX_RCU -- requirements
Module: usb_rx_rcu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port d_edge, input, 1 bit: one-cycle pulse on a D+/D- transition from the edge detector.
REQ-004 SHALL have port eop, input, 1 bit: SE0 level on the bus.
REQ-005 SHALL have port shift_enable, input, 1 bit: bit-sample strobe from the RX bit timer.
REQ-006 SHALL have port byte_received, input, 1 bit: one-cycle pulse from the RX bit timer when the 8th bit is sampled.
REQ-007 SHALL have port rcv_data, input, 8 bits: shift-register byte, LSB-first, valid during the byte_received cycle.
REQ-008 SHALL have port enable_timer, output, 1 bit: runs the RX bit timer.
REQ-009 SHALL have port w_enable, output, 1 bit: one-cycle write strobe to the RX FIFO.
REQ-010 SHALL have port rx_packet, output, 3 bits: decoded PID (0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 bad).
REQ-011 SHALL have port rx_data_ready, output, 1 bit: one-cycle pulse at a clean EOP after a DATA0/DATA1 packet.
REQ-012 SHALL have port rx_transfer_active, output, 1 bit: high from sync detection until return to IDLE.
REQ-013 SHALL have port r_error, output, 1 bit: sticky packet error, cleared on the next d_edge from IDLE.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, SYNC, PID, DATA, STORE, EOP_WAIT, ERR_WAIT, DONE.
REQ-015 IDLE: on d_edge SHALL go to SYNC, assert enable_timer, and clear r_error.
REQ-016 SYNC: on byte_received, rcv_data==8'h80 SHALL go to PID; any other value SHALL go to ERR_WAIT.
REQ-017 PID: on byte_received SHALL decode E1=OUT, 69=IN, C3=DATA0, 4B=DATA1, D2=ACK, 5A=NAK.
REQ-018 PID with a data PID SHALL go to DATA; with a token or handshake PID SHALL go to EOP_WAIT; with any other value SHALL set rx_packet=7 and go to ERR_WAIT.
REQ-019 rx_packet SHALL be registered in the cycle after byte_received and SHALL hold until the next sync detection.
REQ-020 DATA: on byte_received SHALL go to STORE; STORE SHALL pulse w_enable for exactly 1 cycle, then return to DATA.
REQ-021 DATA with eop high on a shift_enable cycle SHALL go to DONE if a whole number of bytes has been received, else to ERR_WAIT.
REQ-022 DATA SHALL count stored bytes in a saturating 7-bit counter; reaching 64 with no EOP SHALL go to ERR_WAIT.
REQ-023 EOP_WAIT: eop on a shift_enable cycle SHALL go to DONE; byte_received before EOP SHALL go to ERR_WAIT.
REQ-024 ERR_WAIT SHALL set r_error, keep enable_timer high, and go to IDLE on the first cycle with eop low after eop was high.
REQ-025 DONE SHALL pulse rx_data_ready for data packets, deassert enable_timer, and go to IDLE next cycle; total latency from EOP strobe to rx_data_ready SHALL be 1 cycle.
REQ-026 If byte_received and eop occur in the same cycle, byte_received SHALL take priority (byte processed, EOP then treated as early/error).
REQ-027 d_edge outside IDLE SHALL be ignored.
REQ-028 enable_timer SHALL be high in every state except IDLE and DONE.

Reset
REQ-029 On rst high at a clock edge the FSM SHALL enter IDLE, with every output 0, rx_packet=0, and the byte counter at 0, regardless of state (including mid-packet).

Structure
REQ-030 State enum, the rx_packet encodings, and constants SYNC_BYTE=8'h80 and MAX_BYTES=64 SHALL live in shared package usb_pkg.
REQ-031 PID decode SHALL be a combinational sub-module, usb_pid_decode (8-bit in, 3-bit out); all else is in usb_rx_rcu.

Verification
REQ-032 Scenario: d_edge, bytes 80, C3, 11, 22, then EOP -> two w_enable pulses, rx_packet=3, one rx_data_ready pulse, no r_error.
REQ-033 Scenario: d_edge, bytes 80, D2, then EOP -> rx_packet=5, no w_enable, no rx_data_ready, return to IDLE.
REQ-034 Scenario: d_edge, byte 81 -> r_error high after EOP, state IDLE, r_error cleared by the next d_edge.
REQ-035 Scenario: bytes 80, 77 -> rx_packet=7, r_error=1.
REQ-036 Scenario: bytes 80, 4B, then 65 data bytes -> 64 w_enable pulses, then r_error.
REQ-037 Scenario: rst high during DATA -> all outputs 0 on the next cycle, state IDLE.
